// File: rtl/mod_counter_gray.sv
`timescale 1ns/1ps
// Modulo-N up/down counter with synchronous load, terminal-count and wrap
// flags, and a registered Gray-coded copy of the count.
module mod_counter_gray #(
  parameter int WIDTH  = 3,
  parameter int MODULO = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_sticky,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] gray,
  output logic             tc,
  output logic             wrap,
  output logic             wrap_sticky
);

  // Reject widths/moduli the count register cannot represent.
  if (WIDTH < 2 || MODULO < 2 || longint'(MODULO) > (64'd1 << WIDTH)) begin : g_bad_param
    $error("mod_counter_gray: illegal WIDTH/MODULO combination");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
  // One extra bit so MODULO = 2^WIDTH is representable for the clamp compare.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULO);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             sticky_q, sticky_d;
  logic             wrap_step;

  // Next-state: load beats count beats hold; sticky set beats clear.
  always_comb begin
    count_d   = count_q;
    wrap_step = 1'b0;
    if (load) begin
      count_d = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_VAL;
    end else if (key) begin
      if (up) begin
        if (count_q == MAX_VAL) begin
          count_d   = '0;
          wrap_step = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          count_d   = MAX_VAL;
          wrap_step = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
    wrap_d   = wrap_step;
    sticky_d = sticky_q;
    if (clr_sticky) sticky_d = 1'b0;
    if (wrap_step)  sticky_d = 1'b1;
    // Gray is derived from the next count so it never lags the binary value.
    gray_d = count_d ^ (count_d >> 1);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= '0;
      gray_q   <= '0;
      wrap_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      gray_q   <= gray_d;
      wrap_q   <= wrap_d;
      sticky_q <= sticky_d;
    end
  end

  // Terminal count follows direction immediately.
  always_comb begin
    tc = up ? (count_q == MAX_VAL) : (count_q == '0);
  end

  assign count       = count_q;
  assign gray        = gray_q;
  assign wrap        = wrap_q;
  assign wrap_sticky = sticky_q;

endmodule

// File: doc/mod_counter_gray.md
# mod_counter_gray

Parametrised synchronous modulo-N up/down counter with synchronous load, count enable, terminal-count and wrap flags, and a registered Gray-coded copy of the count. It generalises the team's fixed 3-bit counter circuit (three state bits, each with a mirrored output) to arbitrary width and modulus. It adds direction control, load, wrap detection and Gray encoding. It sits in the lab designs as the standard state source for sequencers and display drivers.

## Interface
- `WIDTH`, 3, count register width in bits (≥ 2).
- `MODULO`, 8, count modulus; legal range 2 ≤ MODULO ≤ 2^WIDTH. Illegal values are a compile-time error (generate-time check).

- `clk`  in  1  rising-edge clock; the only clock in the block.
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `key`  in  1  count enable; counts one step per cycle while high.
- `up`  in  1  direction: 1 = increment, 0 = decrement.
- `load`  in  1  synchronous load strobe.
- `load_val`  in  WIDTH  value applied on `load`.
- `clr_sticky`  in  1  clears `wrap_sticky`.
- `count`  out  WIDTH  binary count (registered).
- `gray`  out  WIDTH  Gray code of `count`: `count ^ (count >> 1)` (registered, same cycle as `count`).
- `tc`  out  1  terminal count (combinational from `count` and `up`).
- `wrap`  out  1  one-cycle pulse (registered) after a wrap step.
- `wrap_sticky`  out  1  latched wrap indicator.

## Operation
- Priority per rising edge of `clk`: `rst_n` low, then `load`, then `key`, then hold.
- Reset (`rst_n` = 0 at the edge):
  - `count` = 0, `gray` = 0, `wrap` = 0, `wrap_sticky` = 0.
  - `tc` follows its combinational rule on the reset value: it reads 1 if `up` = 0.
- Load:
  - `count` ← `load_val` if `load_val` < MODULO, else `count` ← MODULO−1 (clamp).
  - `load` overrides `key` in the same cycle.
  - A load never raises `wrap`.
- Count (`key` = 1, `load` = 0):
  - Up: `count` == MODULO−1 → 0 (wrap); otherwise `count` + 1.
  - Down: `count` == 0 → MODULO−1 (wrap); otherwise `count` − 1.
  - Arithmetic is WIDTH bits wide. The count never reaches a value ≥ MODULO.
- Hold (`key` = 0, `load` = 0): `count`, `gray` unchanged; `wrap` ← 0.
- `tc` = (`up` & `count` == MODULO−1) | (!`up` & `count` == 0). It changes immediately with `up`.
- `wrap` = 1 for exactly the cycle following an edge on which a wrap step was taken; otherwise 0.
- `wrap_sticky`:
  - Set on any wrap step; cleared when `clr_sticky` = 1.
  - Simultaneous wrap and `clr_sticky`: set wins (sticky = 1).
  - `rst_n` overrides both.
- Direction change mid-count takes effect on the next enabled edge; there is no internal direction state.
- Mod-2^WIDTH case (MODULO = 2^WIDTH): wrap logic is identical to natural overflow, and `tc` is still generated.

## Timing
- Latency from `key`/`load`/`rst_n` sampled at edge N to `count`/`gray`/`wrap` updated after edge N: 1 cycle.
- `gray` is updated from the next-state count, never lagging `count`.
- `tc` has zero-cycle latency (combinational). Bench samples it mid-cycle.
- Reset asserted mid-count: clears on the first edge with `rst_n` = 0, regardless of `load`/`key`. Counting resumes on the first edge with `rst_n` = 1 and `key` = 1.
- No multicycle paths; all outputs except `tc` come directly from flops.

## Test plan
- Reset then up-count, WIDTH=3, MODULO=8, `key`=1, `up`=1:
  - `count` 0,1,…,7,0 on successive cycles; `gray` 0,1,3,2,6,7,5,4,0.
  - `tc`=1 while `count`=7; `wrap`=1 for one cycle when `count` returns to 0; `wrap_sticky`=1 thereafter.
- Down-count, WIDTH=3, MODULO=6:
  - From 0 with `up`=0, `key`=1: `count` 0→5→4→3→2→1→0→5, never 6 or 7.
  - `tc`=1 at 0; `wrap` pulses after each 0→5 step.
- Load and clamp, MODULO=6:
  - `load`=1, `load_val`=7 → `count`=5, `wrap`=0.
  - `load`=1 with `key`=1, `load_val`=2 → `count`=2 (load wins).
- Sticky collision: at `count`=MODULO−1, `up`=1, `key`=1, assert `clr_sticky` in the same cycle → `wrap_sticky`=1. With `clr_sticky`=1 on the next cycle and no wrap → 0.
- Hold and direction flip:
  - `key`=0 for 3 cycles → `count` constant, `wrap`=0.
  - At `count`=0, toggle `up` 1→0 → `tc` goes 0→1 immediately, with no count change.
- Reset mid-operation: at `count`=4 with `wrap_sticky`=1, drop `rst_n` for one cycle while `load`=1, `load_val`=3 → all outputs 0. The next enabled up-count gives `count`=1.
